// File: rtl/layer_one.sv
// layer_one: first binarized convolution layer.
//
// Eight 3x3 binary filters are run over a zero-padded 28x28 binarized image.
// Each convolution output is the number of taps where the weight equals the
// pixel (XNOR popcount). It is thresholded at 5 of 9 and then 2x2 max-pooled
// (OR) with stride 2, giving a 14x14 map per filter. One pooled position is
// produced per cycle for all eight filters, so a full layer takes 196 cycles
// of the s_LAYER_1 state.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         synchronous reset, active HIGH despite the name
//   state         top-level FSM state; 3'b010 selects this layer
//   pixels        784-bit image, pixel (r,c) at bit r*28+c
//   weights       72-bit filter bank, filter f tap k at bit f*9+k (k=kr*3+kc)
//   layer_one_out 1568-bit pooled map, (f,r,c) at bit f*196+r*14+c
//   done          high once all 196 positions have been written
//
// Configuration macro: LAYER_ONE_AUTOCLEAR_EN
//   When defined, leaving s_LAYER_1 after completion clears done and the
//   position counter, so re-entering the state recomputes the layer.
//   When undefined, done stays high until reset.

module layer_one (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    state,
  input  logic [783:0]  pixels,
  input  logic [71:0]   weights,
  output logic [1567:0] layer_one_out,
  output logic          done
);

  localparam logic [2:0] S_LAYER_1 = 3'b010;
  localparam logic [7:0] LAST_POS  = 8'd195;

  logic [7:0] p;
  logic [3:0] pool_row;
  logic [3:0] pool_col;
  logic [7:0] results;
  logic       active;

  assign active   = (state == S_LAYER_1) && !done;
  assign pool_row = 4'(p / 8'd14);
  assign pool_col = 4'(p % 8'd14);

  // For the current pooled position, evaluate the four underlying
  // convolution windows of every filter and OR their thresholded results.
  // Pixels outside the image read as 0 and still take part in the XNOR.
  always_comb begin
    int  y;
    int  x;
    int  i;
    int  j;
    int  m;
    logic pv;
    logic act;
    results = '0;
    y   = 0;
    x   = 0;
    i   = 0;
    j   = 0;
    m   = 0;
    pv  = 1'b0;
    act = 1'b0;
    for (int f = 0; f < 8; f++) begin
      act = 1'b0;
      for (int dy = 0; dy < 2; dy++) begin
        for (int dx = 0; dx < 2; dx++) begin
          y = 2 * int'(pool_row) + dy;
          x = 2 * int'(pool_col) + dx;
          m = 0;
          for (int kr = 0; kr < 3; kr++) begin
            for (int kc = 0; kc < 3; kc++) begin
              i  = y + kr - 1;
              j  = x + kc - 1;
              pv = (i >= 0 && i < 28 && j >= 0 && j < 28) ?
                   pixels[10'(i * 28 + j)] : 1'b0;
              if (weights[7'(f * 9 + kr * 3 + kc)] == pv) begin
                m = m + 1;
              end
            end
          end
          if (m >= 5) begin
            act = 1'b1;
          end
        end
      end
      results[f] = act;
    end
  end

  // Position counter, result storage and completion flag. Only the eight
  // bits of the current position are written; everything else holds, which
  // also covers pausing outside s_LAYER_1 and holding after completion.
  // The counter parks at the last position once done rises.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      layer_one_out <= '0;
      done          <= 1'b0;
      p             <= '0;
    end else if (active) begin
      for (int f = 0; f < 8; f++) begin
        layer_one_out[11'(f * 196) + {3'b000, p}] <= results[f];
      end
      if (p == LAST_POS) begin
        done <= 1'b1;
      end else begin
        p <= p + 8'd1;
      end
    end
`ifdef LAYER_ONE_AUTOCLEAR_EN
    else if ((state != S_LAYER_1) && done) begin
      done <= 1'b0;
      p    <= '0;
    end
`endif
  end

endmodule

// File: tb/tb_layer_one.sv
// tb_layer_one: self-checking bench for layer_one.
//
// Expected pooled maps come from a reference model that builds the full
// 8x28x28 activation image from the convolution rules and then pools it.
// Directed patterns, random images/filters, mid-run reset, pausing and the
// post-completion behaviour (with or without LAYER_ONE_AUTOCLEAR_EN) are
// exercised in one linear sequence.

module tb_layer_one;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [2:0]    state = 3'b000;
  logic [783:0]  pixels = '0;
  logic [71:0]   weights = '0;
  logic [1567:0] layer_one_out;
  logic          done;

  int check_count = 0;
  int fail_count  = 0;

  localparam logic [1567:0] ALL_ONES  = {1568{1'b1}};
  localparam logic [1567:0] ALL_ZEROS = '0;

  layer_one dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .state         (state),
    .pixels        (pixels),
    .weights       (weights),
    .layer_one_out (layer_one_out),
    .done          (done)
  );

  always #5 clk = ~clk;

  // Reference: full-resolution activation image, then 2x2 OR pooling.
  function automatic logic [1567:0] model(input logic [783:0] px, input logic [71:0] w);
    bit act [8][28][28];
    logic [1567:0] res;
    int m;
    int i;
    int j;
    bit pv;
    res = '0;
    for (int f = 0; f < 8; f++) begin
      for (int y = 0; y < 28; y++) begin
        for (int x = 0; x < 28; x++) begin
          m = 0;
          for (int kr = 0; kr < 3; kr++) begin
            for (int kc = 0; kc < 3; kc++) begin
              i = y + kr - 1;
              j = x + kc - 1;
              pv = (i >= 0 && i < 28 && j >= 0 && j < 28) ? px[i * 28 + j] : 1'b0;
              if (w[f * 9 + kr * 3 + kc] == pv) m++;
            end
          end
          act[f][y][x] = (m >= 5);
        end
      end
    end
    for (int f = 0; f < 8; f++) begin
      for (int r = 0; r < 14; r++) begin
        for (int c = 0; c < 14; c++) begin
          res[f * 196 + r * 14 + c] = act[f][2*r][2*c] | act[f][2*r][2*c+1] |
                                      act[f][2*r+1][2*c] | act[f][2*r+1][2*c+1];
        end
      end
    end
    return res;
  endfunction

  // Only positions below n have been written; the rest are still 0 from reset.
  function automatic logic [1567:0] partial(input logic [1567:0] full, input int n);
    logic [1567:0] res;
    res = '0;
    for (int f = 0; f < 8; f++) begin
      for (int q = 0; q < n; q++) begin
        res[f * 196 + q] = full[f * 196 + q];
      end
    end
    return res;
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    check_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkVector(input string tag, input logic [1567:0] observed,
                             input logic [1567:0] expected);
    int diff;
    int first;
    diff  = 0;
    first = -1;
    check_count++;
    assert (observed === expected) else begin
      for (int k = 0; k < 1568; k++) begin
        if (observed[k] !== expected[k]) begin
          diff++;
          if (first < 0) first = k;
        end
      end
      fail_count++;
      $error("FAIL %s: observed %0d differing bits (first at bit %0d), expected 0 differing bits",
             tag, diff, first);
    end
  endtask

  task automatic applyStimulus(input logic [783:0] px, input logic [71:0] w, input logic [2:0] st);
    pixels  = px;
    weights = w;
    state   = st;
  endtask

  task automatic runCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Counts rising edges until done is seen, bounded so a dead DUT still ends.
  task automatic waitDone(output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end while (!done && edges < 400);
  endtask

  task automatic resetDut();
    state = 3'b000;
    rst_n = 1'b1;
    runCycles(2);
    rst_n = 1'b0;
  endtask

  function automatic logic [783:0] randPixels();
    logic [783:0] v;
    for (int i = 0; i < 784; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  function automatic logic [71:0] randWeights();
    logic [71:0] v;
    for (int i = 0; i < 72; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  initial begin
    int edges;
    int total;
    logic [783:0] px;
    logic [71:0]  w;
    logic [1567:0] exp_out;

    @(negedge clk);

    // Reset state
    resetDut();
    checkVector("reset_out", layer_one_out, ALL_ZEROS);
    checkOutput("reset_done", int'(done), 0);

    // All-zero image and filters: every window matches fully
    $display("[TB] zero image, zero weights");
    applyStimulus('0, '0, 3'b010);
    waitDone(edges);
    checkOutput("zero_latency", edges, 196);
    checkVector("zero_out", layer_one_out, ALL_ONES);
    checkVector("zero_out_model", layer_one_out, model('0, '0));

    // Hold after done while still in s_LAYER_1, with changed inputs
    applyStimulus('0, {72{1'b1}}, 3'b010);
    runCycles(5);
    checkOutput("hold_done", int'(done), 1);
    checkVector("hold_out", layer_one_out, ALL_ONES);

    // Leaving s_LAYER_1 after completion
    state = 3'b000;
    runCycles(1);
`ifdef LAYER_ONE_AUTOCLEAR_EN
    checkOutput("autoclear_done", int'(done), 0);
    checkVector("autoclear_out_kept", layer_one_out, ALL_ONES);
    state = 3'b010;
    waitDone(edges);
    checkOutput("autoclear_rerun_latency", edges, 196);
    checkVector("autoclear_rerun_out", layer_one_out, ALL_ZEROS);
`else
    checkOutput("sticky_done", int'(done), 1);
    state = 3'b010;
    runCycles(5);
    checkOutput("sticky_done_reenter", int'(done), 1);
    checkVector("sticky_out", layer_one_out, ALL_ONES);
`endif

    // Zero image, all-ones filters: nothing matches
    $display("[TB] zero image, ones weights");
    resetDut();
    applyStimulus('0, {72{1'b1}}, 3'b010);
    waitDone(edges);
    checkOutput("ones_w_latency", edges, 196);
    checkVector("ones_w_out", layer_one_out, ALL_ZEROS);

    // All-ones image and filters: corners weak but pooled neighbours win
    $display("[TB] ones image, ones weights");
    resetDut();
    applyStimulus({784{1'b1}}, {72{1'b1}}, 3'b010);
    waitDone(edges);
    checkVector("ones_ones_out", layer_one_out, ALL_ONES);

    // Single pixel with a centre-tap filter 0
    $display("[TB] single pixel, centre filter");
    resetDut();
    px = '0;
    px[0] = 1'b1;
    w = '0;
    w[8:0] = 9'b000010000;
    applyStimulus(px, w, 3'b010);
    waitDone(edges);
    checkOutput("corner_f0_bit", int'(layer_one_out[0]), 1);
    checkVector("corner_out", layer_one_out, ALL_ONES);
    checkVector("corner_out_model", layer_one_out, model(px, w));

    // Random images and filters
    for (int t = 0; t < 3; t++) begin
      $display("[TB] random run %0d", t);
      resetDut();
      px = randPixels();
      w  = randWeights();
      applyStimulus(px, w, 3'b010);
      waitDone(edges);
      checkOutput($sformatf("rand%0d_latency", t), edges, 196);
      checkVector($sformatf("rand%0d_out", t), layer_one_out, model(px, w));
    end

    // Reset in the middle of a run, then a clean rerun
    $display("[TB] mid-run reset");
    resetDut();
    px = randPixels();
    w  = randWeights();
    exp_out = model(px, w);
    applyStimulus(px, w, 3'b010);
    runCycles(100);
    checkOutput("midrun_done_low", int'(done), 0);
    checkVector("midrun_partial", layer_one_out, partial(exp_out, 100));
    rst_n = 1'b1;
    runCycles(1);
    checkVector("midrun_reset_out", layer_one_out, ALL_ZEROS);
    checkOutput("midrun_reset_done", int'(done), 0);
    rst_n = 1'b0;
    waitDone(edges);
    checkOutput("midrun_rerun_latency", edges, 196);
    checkVector("midrun_rerun_out", layer_one_out, exp_out);

    // Pause for 10 cycles mid-run
    $display("[TB] pause mid-run");
    resetDut();
    px = randPixels();
    w  = randWeights();
    exp_out = model(px, w);
    applyStimulus(px, w, 3'b010);
    runCycles(50);
    state = 3'b000;
    runCycles(10);
    checkOutput("pause_done_low", int'(done), 0);
    checkVector("pause_partial", layer_one_out, partial(exp_out, 50));
    state = 3'b010;
    waitDone(edges);
    total = 50 + 10 + edges;
    checkOutput("pause_total_edges", total, 206);
    checkVector("pause_out", layer_one_out, exp_out);

    $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
    $finish;
  end

endmodule
